// File: rtl/systolic_array_ctrl_if.sv
// Result-row handshake between the array sequencer and its consumer.
interface systolic_array_ctrl_if #(
    parameter int RW = 2
) ();
    logic          res_valid;
    logic          res_ready;
    logic [RW-1:0] res_row;

    modport master (
        output res_valid,
        output res_row,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_row,
        output res_ready
    );
endinterface

// File: rtl/systolic_array_ctrl.sv
// Job sequencer for an N x N output-stationary systolic MAC array:
// clear, skewed operand feed, settle, then row-by-row result readout.
module systolic_array_ctrl #(
    parameter int N     = 4,
    parameter int K_MAX = 7,
    parameter int KW    = 3,
    parameter int TW    = 4,
    parameter int RW    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [KW-1:0]         k_len,
    output logic                  busy,
    output logic                  pe_clr,
    output logic [TW-1:0]         step_cnt,
    output logic [N-1:0]          a_lane_valid,
    output logic [N-1:0]          b_lane_valid,
    output logic                  done,
    systolic_array_ctrl_if.master res
);

    localparam logic [KW-1:0] KL_MAX    = KW'(K_MAX);
    localparam logic [TW-1:0] SKEW_LAST = TW'(2 * N - 3);
    localparam logic [RW-1:0] ROW_LAST  = RW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_SETTLE,
        S_READOUT,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [KW-1:0] kl_q, kl_d;
    logic [TW-1:0] step_q, step_d;
    logic [RW-1:0] row_q, row_d;
    logic          busy_q, busy_d;
    logic          clr_q, clr_d;
    logic [N-1:0]  mask_q, mask_d;
    logic          res_valid_q, res_valid_d;
    logic          done_q, done_d;

    // Final feed step t = F-1 = kl + 2N - 3.
    logic [TW-1:0] feed_last;
    assign feed_last = TW'(kl_q) + SKEW_LAST;

    always_comb begin
        int diff;
        diff    = 0;
        state_d = state_q;
        kl_d    = kl_q;
        step_d  = step_q;
        row_d   = row_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    kl_d    = (k_len > KL_MAX) ? KL_MAX : k_len;
                    step_d  = '0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                step_d  = '0;
                state_d = (kl_q == '0) ? S_SETTLE : S_FEED;
            end
            S_FEED: begin
                if (step_q == feed_last) begin
                    state_d = S_SETTLE;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            S_SETTLE: begin
                row_d   = '0;
                state_d = S_READOUT;
            end
            S_READOUT: begin
                if (res_valid_q && res.res_ready) begin
                    if (row_q == ROW_LAST) begin
                        row_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (rst) begin
            state_d = S_IDLE;
            kl_d    = '0;
            step_d  = '0;
            row_d   = '0;
        end

        // Outputs are precomputed from next state so they leave a flop.
        busy_d      = (state_d != S_IDLE);
        clr_d       = (state_d == S_CLEAR);
        res_valid_d = (state_d == S_READOUT);
        done_d      = (state_d == S_DONE);
        mask_d      = '0;
        for (int unsigned i = 0; i < N; i++) begin
            diff      = int'(step_d) - int'(i);
            mask_d[i] = (state_d == S_FEED) && (diff >= 0) && (diff < int'(kl_d));
        end
    end

    always_ff @(posedge clk) begin
        state_q     <= state_d;
        kl_q        <= kl_d;
        step_q      <= step_d;
        row_q       <= row_d;
        busy_q      <= busy_d;
        clr_q       <= clr_d;
        mask_q      <= mask_d;
        res_valid_q <= res_valid_d;
        done_q      <= done_d;
    end

    // Reset clears the array combinationally so an aborted job leaves no residue.
    assign pe_clr        = rst | clr_q;
    assign busy          = busy_q;
    assign step_cnt      = step_q;
    assign a_lane_valid  = mask_q;
    assign b_lane_valid  = mask_q;
    assign done          = done_q;
    assign res.res_valid = res_valid_q;
    assign res.res_row   = row_q;

endmodule
